// File: rtl/ibex_imem_arb_pkg.sv
// Shared types for the two-host instruction memory arbiter.
// Host IDs, host count and a one-hot helper for grant/response routing.
package ibex_imem_arb_pkg;

  localparam int unsigned NumHosts = 2;

  typedef enum logic {
    HOST_FETCH = 1'b0,
    HOST_AUX   = 1'b1
  } imem_host_e;

  function automatic logic [NumHosts-1:0] host_onehot(
    input imem_host_e h
  );
    return (h == HOST_AUX) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ibex_imem_arb_id_fifo.sv
// In-order owner FIFO: one 1-bit host ID per granted, unanswered request.
// Ports: clk_i, rst_i (sync high), push_i/data_i, pop_i, head_o, count_o,
// empty_o, full_o. Push is ignored when full, pop is ignored when empty.
module ibex_imem_arb_id_fifo
  import ibex_imem_arb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  imem_host_e                 data_i,
  input  logic                       pop_i,
  output imem_host_e                 head_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  imem_host_e      r_mem [Depth];
  logic [PtrW-1:0] r_wr;
  logic [PtrW-1:0] r_rd;
  logic [CntW-1:0] r_cnt;
  logic            w_push;
  logic            w_pop;

  function automatic logic [PtrW-1:0] ptr_inc(
    input logic [PtrW-1:0] p
  );
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (r_cnt == '0);
  assign full_o  = (r_cnt == CntW'(Depth));
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign head_o  = r_mem[r_rd];
  assign count_o = r_cnt;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= ptr_inc(r_rd);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/ibex_imem_arbiter.sv
// Two-host arbiter onto one req/gnt/rvalid instruction memory port.
// Ports: clk_i, rst_i (sync high); host_req_i/host_addr_i -> host_gnt_o;
// host_rvalid_o/host_rdata_o/host_err_o responses; mem_* memory side;
// busy_o = requests in flight or pending. Define IBEX_IMEM_ARB_RR_EN for
// round-robin between hosts; otherwise host 0 has fixed priority.
module ibex_imem_arbiter
  import ibex_imem_arb_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned AddrWidth      = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumHosts-1:0]                host_req_i,
  input  logic [NumHosts-1:0][AddrWidth-1:0] host_addr_i,
  output logic [NumHosts-1:0]                host_gnt_o,
  output logic [NumHosts-1:0]                host_rvalid_o,
  output logic [31:0]                        host_rdata_o,
  output logic                               host_err_o,
  output logic                               mem_req_o,
  output logic [AddrWidth-1:0]               mem_addr_o,
  input  logic                               mem_gnt_i,
  input  logic                               mem_rvalid_i,
  input  logic [31:0]                        mem_rdata_i,
  input  logic                               mem_err_i,
  output logic                               busy_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic            r_lock;
  imem_host_e      r_sel;
  imem_host_e      w_sel;
  imem_host_e      w_win;
  imem_host_e      w_tie;
  imem_host_e      w_head;
  logic [CntW-1:0] w_count;
  logic            w_can_issue;
  logic            w_push;
  logic            w_empty;
  logic            w_full;

`ifdef IBEX_IMEM_ARB_RR_EN
  imem_host_e r_prio;

  // Favour the host that was not served last.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prio <= HOST_FETCH;
    end else if (w_push) begin
      r_prio <= (w_sel == HOST_FETCH) ? HOST_AUX : HOST_FETCH;
    end
  end

  assign w_tie = r_prio;
`else
  assign w_tie = HOST_FETCH;
`endif

  always_comb begin
    w_win = HOST_FETCH;
    unique case (1'b1)
      (&host_req_i):        w_win = w_tie;
      (host_req_i == 2'b10): w_win = HOST_AUX;
      default:              w_win = HOST_FETCH;
    endcase
  end

  // A stalled request keeps its host until memory grants it.
  assign w_sel       = r_lock ? r_sel : w_win;
  assign w_can_issue = ~w_full;
  assign mem_req_o   = w_can_issue & (r_lock | (|host_req_i));
  assign mem_addr_o  = host_addr_i[w_sel];
  assign w_push      = mem_req_o & mem_gnt_i;
  assign host_gnt_o  = w_push ? host_onehot(w_sel) : '0;

  assign host_rvalid_o = (mem_rvalid_i & ~w_empty) ? host_onehot(w_head)
                                                   : '0;
  assign host_rdata_o  = mem_rdata_i;
  assign host_err_o    = mem_err_i;
  assign busy_o        = (w_count != '0) | mem_req_o;

  // When full, mem_req_o is low and the lock is simply held.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lock <= 1'b0;
      r_sel  <= HOST_FETCH;
    end else if (mem_req_o) begin
      r_lock <= ~mem_gnt_i;
      r_sel  <= w_sel;
    end
  end

  ibex_imem_arb_id_fifo #(
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (w_sel),
    .pop_i   (mem_rvalid_i),
    .head_o  (w_head),
    .count_o (w_count),
    .empty_o (w_empty),
    .full_o  (w_full)
  );

`ifndef SYNTHESIS
  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (rst_i) w_push |-> !w_full);
  a_rvalid_tracked: assert property (
    @(posedge clk_i) disable iff (rst_i) mem_rvalid_i |-> !w_empty);
  a_lock_stable: assert property (
    @(posedge clk_i) disable iff (rst_i)
    r_lock |-> host_req_i[r_sel] &&
      (host_addr_i[r_sel] == $past(host_addr_i[w_sel])));
  a_gnt_onehot: assert property (
    @(posedge clk_i) $onehot0(host_gnt_o));
  a_rvalid_onehot: assert property (
    @(posedge clk_i) $onehot0(host_rvalid_o));
`endif

endmodule

// File: tb/tb_ibex_imem_arbiter.sv
// Bench for ibex_imem_arbiter: directed scenarios plus a random run
// against a queue-based reference model.
module tb_ibex_imem_arbiter;

  localparam int MAXO = 2;
`ifdef IBEX_IMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req;
  logic [1:0][31:0]  addr;
  logic [1:0]        gnt_o;
  logic [1:0]        rv_o;
  logic [31:0]       rdata_o;
  logic              err_o;
  logic              mreq;
  logic [31:0]       maddr;
  logic              mgnt;
  logic              mrv;
  logic [31:0]       mrdata;
  logic              merr;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ibex_imem_arbiter #(
    .MaxOutstanding (MAXO),
    .AddrWidth      (32)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .host_req_i    (req),
    .host_addr_i   (addr),
    .host_gnt_o    (gnt_o),
    .host_rvalid_o (rv_o),
    .host_rdata_o  (rdata_o),
    .host_err_o    (err_o),
    .mem_req_o     (mreq),
    .mem_addr_o    (maddr),
    .mem_gnt_i     (mgnt),
    .mem_rvalid_i  (mrv),
    .mem_rdata_i   (mrdata),
    .mem_err_i     (merr),
    .busy_o        (busy)
  );

  // Reference model: owners of in-flight requests, pending stalled host,
  // favoured host for ties.
  int         owners[$];
  bit         m_locked;
  int         m_lhost;
  int         m_fav;
  int         e_host;
  bit         e_mreq;
  bit         e_busy;
  logic [31:0] e_addr;
  logic [1:0] e_gnt;
  logic [1:0] e_rv;

  task automatic model_eval();
    int h;
    if (m_locked) h = m_lhost;
    else if (req == 2'b11) h = RR ? m_fav : 0;
    else if (req == 2'b10) h = 1;
    else h = 0;
    e_host = h;
    e_mreq = (owners.size() < MAXO) && (m_locked || req != 2'b00);
    e_addr = addr[h];
    e_gnt  = (e_mreq && mgnt) ? 2'(1 << h) : 2'b00;
    e_rv   = (mrv && owners.size() > 0) ? 2'(1 << owners[0]) : 2'b00;
    e_busy = (owners.size() != 0) || e_mreq;
  endtask

  task automatic model_commit();
    if (rst) begin
      owners.delete();
      m_locked = 1'b0;
      m_lhost  = 0;
      m_fav    = 0;
      return;
    end
    if (e_rv != 2'b00) void'(owners.pop_front());
    if (e_gnt != 2'b00) begin
      owners.push_back(e_host);
      m_fav = 1 - e_host;
    end
    if (e_mreq) begin
      m_locked = !mgnt;
      m_lhost  = e_host;
    end
  endtask

  task automatic idle();
    req    = 2'b00;
    mgnt   = 1'b0;
    mrv    = 1'b0;
    mrdata = '0;
    merr   = 1'b0;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    addr[0] = 32'hA5A5_0000;
    addr[1] = 32'h5A5A_0000;
    tick();
    settle();
    n_tests++;
    if ({mreq, gnt_o, rv_o, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outs got %b want 000000",
               {mreq, gnt_o, rv_o, busy});
    end
    n_tests++;
    if (maddr !== 32'hA5A5_0000) begin
      n_fail++;
      $display("FAIL reset_addr got %h want a5a50000", maddr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req = 2'b01; addr[0] = 32'h100; mgnt = 1'b1;
    settle();
    n_tests++;
    if ({mreq, gnt_o, maddr} !== {1'b1, 2'b01, 32'h100}) begin
      n_fail++;
      $display("FAIL single_gnt got %b/%b/%h want 1/01/00000100",
               mreq, gnt_o, maddr);
    end
    tick();
    idle();
    settle();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy got %b want 1", busy);
    end
    tick();
    mrv = 1'b1; mrdata = 32'hDEADBEEF;
    settle();
    n_tests++;
    if ({rv_o, rdata_o} !== {2'b01, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL single_rvalid got %b/%h want 01/deadbeef",
               rv_o, rdata_o);
    end
    tick();
    idle();
    settle();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain got %b want 0", busy);
    end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    req = 2'b11; addr[0] = 32'h200; addr[1] = 32'h300;
    for (int i = 0; i < 4; i++) begin
      mgnt = (i == 3);
      settle();
      n_tests++;
      if ({maddr, gnt_o} !== {32'h200, (i == 3) ? 2'b01 : 2'b00}) begin
        n_fail++;
        $display("FAIL stall_cyc%0d got %h/%b want 00000200/%b",
                 i, maddr, gnt_o, (i == 3) ? 2'b01 : 2'b00);
      end
      tick();
    end
    req = 2'b10; mgnt = 1'b1;
    settle();
    n_tests++;
    if ({maddr, gnt_o} !== {32'h300, 2'b10}) begin
      n_fail++;
      $display("FAIL stall_host1 got %h/%b want 00000300/10", maddr, gnt_o);
    end
    tick();
    idle(); mrv = 1'b1; mrdata = 32'hAAAA0000;
    settle();
    n_tests++;
    if ({rv_o, rdata_o} !== {2'b01, 32'hAAAA0000}) begin
      n_fail++;
      $display("FAIL stall_rsp0 got %b/%h want 01/aaaa0000", rv_o, rdata_o);
    end
    tick();
    mrdata = 32'hBBBB0000;
    settle();
    n_tests++;
    if ({rv_o, rdata_o} !== {2'b10, 32'hBBBB0000}) begin
      n_fail++;
      $display("FAIL stall_rsp1 got %b/%h want 10/bbbb0000", rv_o, rdata_o);
    end
    tick();
    idle();
  endtask

  task automatic test_lock();
    do_reset();
    req = 2'b10; addr[1] = 32'h800;
    settle();
    tick();
    req = 2'b11; addr[0] = 32'h900;
    settle();
    n_tests++;
    if ({maddr, gnt_o} !== {32'h800, 2'b00}) begin
      n_fail++;
      $display("FAIL lock_hold got %h/%b want 00000800/00", maddr, gnt_o);
    end
    tick();
    mgnt = 1'b1;
    settle();
    n_tests++;
    if (gnt_o !== 2'b10) begin
      n_fail++;
      $display("FAIL lock_gnt got %b want 10", gnt_o);
    end
    tick();
    req = 2'b01;
    settle();
    n_tests++;
    if ({maddr, gnt_o} !== {32'h900, 2'b01}) begin
      n_fail++;
      $display("FAIL lock_next got %h/%b want 00000900/01", maddr, gnt_o);
    end
    tick();
    idle(); mrv = 1'b1;
    settle();
    n_tests++;
    if (rv_o !== 2'b10) begin
      n_fail++;
      $display("FAIL lock_rsp0 got %b want 10", rv_o);
    end
    tick();
    settle();
    n_tests++;
    if (rv_o !== 2'b01) begin
      n_fail++;
      $display("FAIL lock_rsp1 got %b want 01", rv_o);
    end
    tick();
    idle();
  endtask

  task automatic test_rr_full();
    do_reset();
    req = 2'b11; addr[0] = 32'h400; addr[1] = 32'h500; mgnt = 1'b1;
    settle();
    n_tests++;
    if (gnt_o !== 2'b01) begin
      n_fail++;
      $display("FAIL rr_first got %b want 01", gnt_o);
    end
    tick();
    addr[0] = 32'h404;
    settle();
    n_tests++;
    if (gnt_o !== (RR ? 2'b10 : 2'b01)) begin
      n_fail++;
      $display("FAIL rr_second got %b want %b", gnt_o, RR ? 2'b10 : 2'b01);
    end
    tick();
    req = RR ? 2'b01 : 2'b10; mrv = 1'b1;
    settle();
    n_tests++;
    if ({mreq, gnt_o, rv_o} !== {1'b0, 2'b00, 2'b01}) begin
      n_fail++;
      $display("FAIL full_mask got %b/%b/%b want 0/00/01",
               mreq, gnt_o, rv_o);
    end
    tick();
    settle();
    n_tests++;
    if ({gnt_o, rv_o, maddr} !==
        {RR ? 4'b0110 : 4'b1001, RR ? 32'h404 : 32'h500}) begin
      n_fail++;
      $display("FAIL push_pop got %b/%b/%h want %b", gnt_o, rv_o, maddr,
               RR ? 4'b0110 : 4'b1001);
    end
    tick();
    req = 2'b00; mgnt = 1'b0;
    settle();
    n_tests++;
    if ({rv_o, busy} !== {RR ? 2'b01 : 2'b10, 1'b1}) begin
      n_fail++;
      $display("FAIL push_pop_head got %b/%b want %b/1", rv_o, busy,
               RR ? 2'b01 : 2'b10);
    end
    tick();
    idle();
    settle();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_drain got %b want 0", busy);
    end
    tick();
  endtask

  task automatic test_order();
    do_reset();
    req = 2'b01; addr[0] = 32'h600; mgnt = 1'b1;
    settle();
    tick();
    req = 2'b10; addr[1] = 32'h700;
    settle();
    n_tests++;
    if (gnt_o !== 2'b10) begin
      n_fail++;
      $display("FAIL order_gnt1 got %b want 10", gnt_o);
    end
    tick();
    idle(); mrv = 1'b1; mrdata = 32'h1111_1111;
    settle();
    n_tests++;
    if ({rv_o, rdata_o} !== {2'b01, 32'h1111_1111}) begin
      n_fail++;
      $display("FAIL order_rsp0 got %b/%h want 01/11111111", rv_o, rdata_o);
    end
    tick();
    req = 2'b01; addr[0] = 32'h604; mgnt = 1'b1; mrdata = 32'h2222_2222;
    settle();
    n_tests++;
    if ({gnt_o, rv_o, rdata_o} !== {2'b01, 2'b10, 32'h2222_2222}) begin
      n_fail++;
      $display("FAIL order_rsp1 got %b/%b/%h want 01/10/22222222",
               gnt_o, rv_o, rdata_o);
    end
    tick();
    idle(); mrv = 1'b1; mrdata = 32'h3333_3333; merr = 1'b1;
    settle();
    n_tests++;
    if ({rv_o, rdata_o, err_o} !== {2'b01, 32'h3333_3333, 1'b1}) begin
      n_fail++;
      $display("FAIL order_rsp2 got %b/%h/%b want 01/33333333/1",
               rv_o, rdata_o, err_o);
    end
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 2'b01; addr[0] = 32'hA00; mgnt = 1'b1;
    settle();
    tick();
    req = 2'b10; addr[1] = 32'hB00; mgnt = 1'b0;
    settle();
    n_tests++;
    if ({mreq, gnt_o, busy} !== {1'b1, 2'b00, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_pre got %b want 1001", {mreq, gnt_o, busy});
    end
    tick();
    rst = 1'b1;
    settle();
    tick();
    rst = 1'b0;
    idle();
    settle();
    n_tests++;
    if ({mreq, gnt_o, rv_o, busy, maddr} !== {6'b0, 32'hA00}) begin
      n_fail++;
      $display("FAIL midrst_post got %b/%h want 000000/00000a00",
               {mreq, gnt_o, rv_o, busy}, maddr);
    end
    tick();
  endtask

  task automatic test_random();
    bit pend[2];
    do_reset();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && $urandom_range(0, 2) == 0) begin
          pend[n] = 1'b1;
          addr[n] = $urandom & 32'hFFFF_FFFC;
        end
      end
      req    = {pend[1], pend[0]};
      mgnt   = 1'($urandom_range(0, 1));
      mrv    = (owners.size() > 0) && ($urandom_range(0, 2) != 0);
      mrdata = $urandom;
      merr   = 1'($urandom_range(0, 1));
      settle();
      n_tests++;
      if ({mreq, gnt_o, rv_o, busy} !== {e_mreq, e_gnt, e_rv, e_busy}) begin
        n_fail++;
        $display("FAIL rnd_ctl c%0d got %b want %b", c,
                 {mreq, gnt_o, rv_o, busy}, {e_mreq, e_gnt, e_rv, e_busy});
      end
      n_tests++;
      if (maddr !== e_addr) begin
        n_fail++;
        $display("FAIL rnd_addr c%0d got %h want %h", c, maddr, e_addr);
      end
      n_tests++;
      if ({rdata_o, err_o} !== {mrdata, merr}) begin
        n_fail++;
        $display("FAIL rnd_data c%0d got %h/%b want %h/%b", c,
                 rdata_o, err_o, mrdata, merr);
      end
      tick();
      for (int n = 0; n < 2; n++) begin
        if (e_gnt[n]) pend[n] = 1'b0;
      end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    addr = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_stall();
    test_lock();
    test_rr_full();
    test_order();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
